// File: rtl/arb_req_agent.sv
// Requester-side front end for a round-robin arbiter. Each channel has a command FIFO and an FSM
// that raises req, consumes the one-hot grant, and issues the burst as beats on a shared bus.
module arb_req_agent #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       cmd_valid,
    output logic [N-1:0]       cmd_ready,
    input  logic [N*LEN_W-1:0] cmd_len,
    output logic [N-1:0]       req,
    input  logic [N-1:0]       gnt,
    output logic               beat_valid,
    output logic [ID_W-1:0]    beat_id,
    output logic               beat_last,
    output logic               err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_e;

    state_e           state_q [N];
    state_e           state_d [N];
    logic [LEN_W-1:0] mem_q   [N][DEPTH];
    logic [LEN_W-1:0] mem_d   [N][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [N];
    logic [PTR_W-1:0] wr_ptr_d [N];
    logic [PTR_W-1:0] rd_ptr_q [N];
    logic [PTR_W-1:0] rd_ptr_d [N];
    logic [CNT_W-1:0] count_q [N];
    logic [CNT_W-1:0] count_d [N];
    logic [LEN_W-1:0] cnt_q   [N];
    logic [LEN_W-1:0] cnt_d   [N];
    logic [N-1:0]     req_q, req_d;
    logic             err_q, err_d;

    logic             multi_hot;
    logic [N-1:0]     gnt_eff;
    logic [N-1:0]     full, empty, push, pop, beat, stray;

    // A multi-hot grant is illegal and acts as no grant at all for that cycle.
    always_comb begin
        multi_hot = ($countones(gnt) > 1);
        gnt_eff   = multi_hot ? '0 : gnt;
        for (int i = 0; i < N; i++) begin
            full[i]  = (count_q[i] == CNT_W'(DEPTH));
            empty[i] = (count_q[i] == '0);
            push[i]  = cmd_valid[i] & ~full[i];
            pop[i]   = (state_q[i] == REQ) & gnt_eff[i];
            beat[i]  = (state_q[i] == XFER) & gnt_eff[i];
            stray[i] = gnt[i] & ((state_q[i] == IDLE) | (state_q[i] == GAP));
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            mem_d[i]    = mem_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = cmd_len[i*LEN_W +: LEN_W];
                wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                cnt_d[i]    = mem_q[i][rd_ptr_q[i]];
            end else if (beat[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // Next-state logic: GAP drops req for one cycle so the arbiter can rotate.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (!empty[i]) state_d[i] = REQ;
                REQ:     if (pop[i]) state_d[i] = XFER;
                XFER:    if (beat[i] && (cnt_q[i] == '0)) state_d[i] = GAP;
                GAP:     state_d[i] = empty[i] ? IDLE : REQ;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Outputs: req is registered from the next state, beats decode from state and grant.
    always_comb begin
        beat_valid = |beat;
        beat_id    = '0;
        beat_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_d[i] = (state_d[i] == REQ) || (state_d[i] == XFER);
            if (beat[i]) begin
                beat_id   = ID_W'(i);
                beat_last = (cnt_q[i] == '0);
            end
        end
        err_d = err_q | multi_hot | (|stray);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= IDLE;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                cnt_q[i]    <= '0;
            end
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i]  <= state_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            req_q <= req_d;
            err_q <= err_d;
        end
    end

    // Storage needs no reset; the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cmd_ready = ~full;
    assign req       = req_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Self-checking bench for arb_req_agent: a beat scoreboard fed at stimulus time, plus a
// small round-robin arbiter model that grants from the agent's req and locks until req drops.
module tb_arb_req_agent;

    typedef struct packed {
        logic [1:0] id;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cmd_valid = '0;
    logic [3:0]  cmd_ready;
    logic [15:0] cmd_len = '0;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        beat_valid;
    logic [1:0]  beat_id;
    logic        beat_last;
    logic        err;

    int    vectors = 0;
    int    miscompares = 0;
    int    beat_cnt = 0;
    logic  mon_en = 1'b0;
    beat_t sb[$];
    beat_t exp_b;

    logic       arb_en = 1'b0;
    logic [3:0] gnt_man = '0;
    logic [3:0] arb_gnt;
    int         last_q = 3;
    int         own_q = 0;
    logic       own_v = 1'b0;

    always #5 clk = ~clk;

    arb_req_agent #(.N(4), .DEPTH(4), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .req(req), .gnt(gnt),
        .beat_valid(beat_valid), .beat_id(beat_id), .beat_last(beat_last),
        .err(err)
    );

    function automatic int idx_of(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    // Round-robin model: keep the owner while its req is high, else search after the last owner.
    always_comb begin
        arb_gnt = '0;
        if (own_v && req[own_q]) begin
            arb_gnt[own_q] = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (arb_gnt == '0 && req[(last_q + k) % 4] === 1'b1) arb_gnt[(last_q + k) % 4] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            last_q <= 3;
            own_v  <= 1'b0;
        end else if (arb_en && arb_gnt != '0) begin
            own_q  <= idx_of(arb_gnt);
            last_q <= idx_of(arb_gnt);
            own_v  <= 1'b1;
        end else if (own_v && !req[own_q]) begin
            own_v <= 1'b0;
        end
    end

    assign gnt = arb_en ? arb_gnt : gnt_man;

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (beat_valid === 1'b1) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL beat_unexpected: got id=%0d last=%0b, required no beat", beat_id, beat_last);
                end else begin
                    exp_b = sb.pop_front();
                    if (beat_id !== exp_b.id || beat_last !== exp_b.last) begin
                        miscompares++;
                        $display("[TB] FAIL beat_data: got id=%0d last=%0b, required id=%0d last=%0b",
                                 beat_id, beat_last, exp_b.id, exp_b.last);
                    end
                end
            end else if (beat_valid !== 1'b0 || beat_id !== 2'd0 || beat_last !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL beat_idle: got valid=%b id=%b last=%b, required 0/0/0", beat_valid, beat_id, beat_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic do_reset();
        arb_en    = 1'b0;
        gnt_man   = '0;
        cmd_valid = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic expect_burst(input int ch, input int len);
        beat_t b;
        for (int k = 0; k <= len; k++) begin
            b.id   = 2'(ch);
            b.last = (k == len);
            sb.push_back(b);
        end
    endtask

    task automatic push_cmd(input int ch, input logic [3:0] len);
        cmd_valid[ch]        = 1'b1;
        cmd_len[ch*4 +: 4]   = len;
        tick();
        cmd_valid = '0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) tick();
        settle();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        settle();
        check4("reset_req", req, 4'b0000);
        check4("reset_cmd_ready", cmd_ready, 4'b1111);
        check4("reset_beat", {beat_valid, beat_id, beat_last}, 4'b0000);
        check4("reset_err", {3'b000, err}, 4'b0000);
    endtask

    task automatic test_single();
        int base;
        do_reset();
        arb_en = 1'b1;
        push_cmd(2, 4'd3);
        expect_burst(2, 3);
        settle();
        check4("single_no_bypass", req, 4'b0000);
        tick();
        settle();
        check4("single_req", req, 4'b0100);
        base = beat_cnt;
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            check4("single_xfer", {2'b00, beat_valid, req[2]}, 4'b0011);
        end
        check4("single_beats", 4'(beat_cnt - base), 4'd4);
        tick();
        settle();
        check4("single_gap", {req[3:1], beat_valid}, 4'b0000);
        tick();
        settle();
        check4("single_idle", req, 4'b0000);
        check4("single_err", {3'b000, err}, 4'b0000);
        drain("single", 2);
    endtask

    task automatic test_contention();
        int   base;
        int   prev_id = 0;
        logic prev_last = 1'b0;
        do_reset();
        arb_en    = 1'b1;
        cmd_valid = 4'b1011;
        cmd_len   = 16'h1011;
        tick();
        cmd_valid = '0;
        expect_burst(0, 1);
        expect_burst(1, 1);
        expect_burst(3, 1);
        base = beat_cnt;
        for (int k = 0; k < 30; k++) begin
            tick();
            settle();
            if (prev_last) check4("contention_gap", {3'b000, req[prev_id]}, 4'b0000);
            prev_last = (beat_valid === 1'b1) && (beat_last === 1'b1);
            prev_id   = int'(beat_id);
        end
        check4("contention_beats", 4'(beat_cnt - base), 4'd6);
        check4("contention_err", {3'b000, err}, 4'b0000);
        drain("contention", 2);
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            settle();
            check4("full_ready_before", {3'b000, cmd_ready[1]}, 4'b0001);
            push_cmd(1, 4'd0);
            expect_burst(1, 0);
        end
        settle();
        check4("full_ready_low", {3'b000, cmd_ready[1]}, 4'b0000);
        cmd_valid[1] = 1'b1;
        cmd_len[7:4] = 4'd2;
        tick();
        settle();
        check4("full_held", {2'b00, cmd_ready[1], req[1]}, 4'b0001);
        arb_en = 1'b1;
        tick();
        settle();
        check4("full_ready_rise", {3'b000, cmd_ready[1]}, 4'b0001);
        tick();
        cmd_valid = '0;
        expect_burst(1, 2);
        drain("full", 40);
        tick();
        settle();
        check4("full_final_ready", cmd_ready, 4'b1111);
        check4("full_final_req", req, 4'b0000);
    endtask

    task automatic test_grant_stall();
        int         base;
        logic [4:0] pattern = 5'b10101;
        do_reset();
        push_cmd(0, 4'd2);
        expect_burst(0, 2);
        tick();
        settle();
        check4("stall_req", req, 4'b0001);
        gnt_man = 4'b0001;
        tick();
        base = beat_cnt;
        for (int j = 0; j < 5; j++) begin
            gnt_man = pattern[j] ? 4'b0001 : 4'b0000;
            settle();
            check4("stall_cycle", {2'b00, beat_valid, req[0]}, {2'b00, pattern[j], 1'b1});
            tick();
        end
        gnt_man = '0;
        settle();
        check4("stall_beats", 4'(beat_cnt - base), 4'd3);
        check4("stall_gap", req, 4'b0000);
        drain("stall", 2);
    endtask

    task automatic test_protocol_error();
        do_reset();
        cmd_valid = 4'b0101;
        cmd_len   = 16'h0000;
        tick();
        cmd_valid = '0;
        tick();
        settle();
        check4("perr_req", req, 4'b0101);
        check4("perr_err_before", {3'b000, err}, 4'b0000);
        gnt_man = 4'b0101;
        tick();
        tick();
        settle();
        check4("perr_no_beat", {3'b000, beat_valid}, 4'b0000);
        gnt_man = '0;
        settle();
        check4("perr_err_set", {3'b000, err}, 4'b0001);
        check4("perr_no_pop", req, 4'b0101);
        gnt_man = 4'b1000;
        tick();
        gnt_man = '0;
        settle();
        check4("perr_ignored", {beat_valid, req[2:0]}, 4'b0101);
        check4("perr_sticky", {3'b000, err}, 4'b0001);
        arb_en = 1'b1;
        expect_burst(0, 0);
        expect_burst(2, 0);
        drain("perr", 30);
        check4("perr_still_sticky", {3'b000, err}, 4'b0001);
        do_reset();
        settle();
        check4("perr_cleared", {3'b000, err}, 4'b0000);
        gnt_man = 4'b1000;
        tick();
        gnt_man = '0;
        settle();
        check4("perr_idle_grant", {3'b000, err}, 4'b0001);
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        int   base;
        logic hit = 1'b0;
        do_reset();
        arb_en = 1'b1;
        push_cmd(2, 4'd15);
        push_cmd(2, 4'd3);
        expect_burst(2, 15);
        base = beat_cnt;
        for (int k = 0; k < 40 && !hit; k++) begin
            settle();
            if (beat_cnt - base >= 5) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("[TB] FAIL midrst_timeout: got %0d beats, required 5", beat_cnt - base);
        end
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        settle();
        check4("midrst_req", req, 4'b0000);
        check4("midrst_ready", cmd_ready, 4'b1111);
        check4("midrst_out", {beat_valid, 2'b00, err}, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            settle();
            check4("midrst_empty", {req[3:1], req[0] | beat_valid}, 4'b0000);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fifo_full();
        test_grant_stall();
        test_protocol_error();
        test_reset_mid_burst();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL final_scoreboard: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
